// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order IMEM reads against a credit budget, buffers the
// returning words with their PCs for decode, and flushes/discards in-flight work on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned IMEM_AWIDTH = 17,
  parameter int unsigned TIMEOUT     = 100
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic        exception,
  output logic        stall_timeout
);

  // Handshakes: imem_ready is a request strobe (memory never back-pressures; one word per
  // asserted cycle) and imem_valid returns words in request order. Toward decode the head
  // transfers on every cycle with if_valid && id_ready, except a redirect cycle (flush wins).

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
  localparam logic [SW-1:0] TIMEOUT_W = SW'(TIMEOUT);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [SW-1:0] stall_cnt;
  logic          exc;

  logic [CW:0]   credit_sum;
  logic [CW:0]   discard_sum;
  logic          credit_ok;
  logic          addr_bad;
  logic          issue_cond;
  logic          issue;
  logic          push;
  logic          pop;

  always_comb begin
    credit_sum  = {1'b0, count} + {1'b0, outstanding};
    credit_ok   = credit_sum < DEPTH_W;
    addr_bad    = (fetch_pc >> IMEM_AWIDTH) != 32'd0;
    issue_cond  = credit_ok && !exc && !redirect_valid;
    issue       = issue_cond && !addr_bad;
    push        = imem_valid && (discard == '0) && !redirect_valid;
    pop         = if_valid && id_ready && !redirect_valid;
    // Everything still in flight becomes garbage; a word landing this cycle is already gone.
    discard_sum = {1'b0, discard} + {1'b0, outstanding} - (CW + 1)'(imem_valid);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      exc         <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        outstanding <= '0;
        discard     <= discard_sum[CW-1:0];
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding + CW'(issue) - CW'(push);
        if (imem_valid && (discard != '0)) discard <= discard - CW'(1);
      end
      // Sticky until reset; an out-of-range fetch is flagged instead of being requested.
      if ((redirect_valid && (redirect_pc[1:0] != 2'b00)) || (issue_cond && addr_bad))
        exc <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stall_cnt <= '0;
    end else if (redirect_valid || pop || !if_valid) begin
      stall_cnt <= '0;
    end else if (!id_ready && (stall_cnt != TIMEOUT_W)) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign imem_ready    = issue;
  assign imem_addr     = fetch_pc;
  assign if_valid      = count != '0;
  assign if_pc         = if_valid ? pc_mem[rd_ptr] : 32'd0;
  assign if_instr      = if_valid ? instr_mem[rd_ptr] : 32'd0;
  assign exception     = exc;
  assign stall_timeout = stall_cnt == TIMEOUT_W;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with adjustable latency where word n
// lives at byte address 4n, plus one task per feature with hand-derived expectations.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        resetb;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        exception;
  logic        stall_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          cyc     = 0;
  int          lat     = 1;
  int          req_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic        saw_oob   = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IMEM_AWIDTH(17), .TIMEOUT(100)) dut (
    .clk(clk), .resetb(resetb), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .exception(exception), .stall_timeout(stall_timeout)
  );

  // Memory: present the oldest due word just after the edge, record requests at mid-cycle.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!resetb) mem_q.delete();
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_valid = 1'b1;
        imem_rdata = mem_q[0].data;
        mem_q.delete(0);
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
      end
      @(negedge clk);
      if (!resetb) begin
        mem_q.delete();
      end else if (imem_ready) begin
        mem_q.push_back('{due: cyc + lat, data: imem_addr >> 2});
        req_cnt++;
        last_addr = imem_addr;
        if (imem_addr >= 32'h0002_0000) saw_oob = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at the start of cycle 0 with reset released.
  task automatic reset_dut(input logic rdy, input int l);
    resetb = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = rdy; lat = l;
    repeat (3) tick();
    resetb = 1'b1; req_cnt = 0; saw_oob = 1'b0;
  endtask

  task automatic test_reset;
    resetb = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1) begin failures++; $display("FAIL rst_imem_ready: got %b expected 1", imem_ready); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_imem_addr: got %h expected 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_if_instr: got %h expected 0", if_instr); end
    checks++; if (exception !== 1'b0) begin failures++; $display("FAIL rst_exception: got %b expected 0", exception); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL rst_stall_timeout: got %b expected 0", stall_timeout); end
  endtask

  // 1-cycle memory, decode always ready: two fill cycles, then one instruction per cycle.
  task automatic test_stream;
    reset_dut(1'b1, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL stream_first_addr: got %h expected 0", imem_addr); end
      end
      checks++; if (if_valid !== (k >= 2)) begin failures++; $display("FAIL stream_valid c%0d: got %b expected %b", k, if_valid, k >= 2); end
      if (k >= 2) begin
        checks++; if (if_pc !== 32'(4 * (k - 2))) begin failures++; $display("FAIL stream_pc c%0d: got %h expected %h", k, if_pc, 4 * (k - 2)); end
        checks++; if (if_instr !== 32'(k - 2)) begin failures++; $display("FAIL stream_instr c%0d: got %h expected %h", k, if_instr, k - 2); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    reset_dut(1'b0, 1);
    for (int k = 0; k < 8; k++) begin @(negedge clk); tick(); end
    @(negedge clk);
    checks++; if (req_cnt !== 4) begin failures++; $display("FAIL bp_req_cnt: got %0d expected 4", req_cnt); end
    checks++; if (imem_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %b expected 0", imem_ready); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got %h expected 0", if_pc); end
    tick(); id_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_pop_cycle: got %b expected 0", imem_ready); end
    tick(); id_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL bp_refill_req: got %b/%h expected 1/00000010", imem_ready, imem_addr); end
    checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL bp_head_after_pop: got %h expected 4", if_pc); end
    tick();
    for (int k = 0; k < 5; k++) begin @(negedge clk); tick(); end
    @(negedge clk);
    checks++; if (req_cnt !== 5 || last_addr !== 32'h10) begin failures++; $display("FAIL bp_one_refill: got %0d/%h expected 5/00000010", req_cnt, last_addr); end
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
    tick(); id_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      if (if_valid) begin
        checks++; if (if_pc !== exp_q[0]) begin failures++; $display("FAIL bp_drain_pc: got %h expected %h", if_pc, exp_q[0]); end
        exp_q.delete(0);
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  // Redirect in C with 1-cycle memory: request in C+1, word in C+2, visible in C+3.
  // Then two redirects in consecutive cycles: only the second target is fetched.
  task automatic test_redirect_timing;
    reset_dut(1'b1, 1);
    for (int k = 0; k < 6; k++) begin @(negedge clk); tick(); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_req: got %b/%h expected 1/00000100", imem_ready, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_c1: got %b expected 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_empty_c2: got %b expected 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h40) begin failures++; $display("FAIL redir_head_c3: got %b/%h/%h expected 1/00000100/00000040", if_valid, if_pc, if_instr); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    tick(); redirect_pc = 32'h300;
    @(negedge clk);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL b2b_req: got %b/%h expected 1/00000300", imem_ready, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %b expected 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty2: got %b expected 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'hC0) begin failures++; $display("FAIL b2b_head: got %b/%h/%h expected 1/00000300/000000c0", if_valid, if_pc, if_instr); end
  endtask

  // 3-cycle memory; redirect in cycle 4 with outstanding=3. Old words arrive in C, C+1, C+2
  // and are dropped; the 0x40 request (C+1) queues behind them, lands in C+3, visible in C+4.
  task automatic test_redirect_flush;
    int rise;
    rise = -1;
    reset_dut(1'b0, 3);
    for (int k = 0; k < 4; k++) begin @(negedge clk); tick(); end
    redirect_valid = 1'b1; redirect_pc = 32'h40; lat = 1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || imem_ready !== 1'b0) begin failures++; $display("FAIL flush_pre: got %b/%b expected 1/0", if_valid, imem_ready); end
    tick(); redirect_valid = 1'b0;
    for (int n = 1; n <= 8 && rise < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL flush_req: got %b/%h expected 1/00000040", imem_ready, imem_addr); end
      end
      if (if_valid) begin
        rise = n;
        checks++; if (if_pc !== 32'h40 || if_instr !== 32'h10) begin failures++; $display("FAIL flush_head: got %h/%h expected 00000040/00000010", if_pc, if_instr); end
      end
      tick();
    end
    checks++; if (rise !== 4) begin failures++; $display("FAIL flush_rise: got C+%0d expected C+4", rise); end
  endtask

  task automatic test_misaligned;
    int bad;
    bad = 0;
    reset_dut(1'b0, 1);
    for (int k = 0; k < 8; k++) begin @(negedge clk); tick(); end
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    checks++; if (exception !== 1'b0) begin failures++; $display("FAIL mis_exc_early: got %b expected 0", exception); end
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (exception !== 1'b1 || imem_ready !== 1'b0) begin failures++; $display("FAIL mis_exc: got %b/%b expected 1/0", exception, imem_ready); end
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      if (imem_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mis_ready_held: got %0d issuing cycles expected 0", bad); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (exception !== 1'b1 || imem_ready !== 1'b0) begin failures++; $display("FAIL mis_sticky: got %b/%b expected 1/0", exception, imem_ready); end
  endtask

  task automatic test_addr_limit;
    reset_dut(1'b0, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h1FFFC;
    @(negedge clk);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h1FFFC) begin failures++; $display("FAIL lim_last_req: got %b/%h expected 1/0001fffc", imem_ready, imem_addr); end
    tick(); @(negedge clk);
    checks++; if (imem_ready !== 1'b0 || exception !== 1'b0) begin failures++; $display("FAIL lim_no_req: got %b/%b expected 0/0", imem_ready, exception); end
    tick(); @(negedge clk);
    checks++; if (exception !== 1'b1) begin failures++; $display("FAIL lim_exc: got %b expected 1", exception); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1FFFC || if_instr !== 32'h7FFF) begin failures++; $display("FAIL lim_head: got %b/%h/%h expected 1/0001fffc/00007fff", if_valid, if_pc, if_instr); end
    tick(); id_ready = 1'b1;
    @(negedge clk);
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_ready !== 1'b0) begin failures++; $display("FAIL lim_drained: got %b/%b expected 0/0", if_valid, imem_ready); end
    checks++; if (saw_oob !== 1'b0 || req_cnt !== 1) begin failures++; $display("FAIL lim_oob: got %b/%0d expected 0/1", saw_oob, req_cnt); end
  endtask

  task automatic test_stall_timeout;
    int w;
    w = 0;
    reset_dut(1'b0, 1);
    @(negedge clk);
    while (!if_valid && w < 10) begin tick(); @(negedge clk); w++; end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_fill_timeout: got %b expected 1", if_valid); end
    repeat (99) tick();
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL stall_99: got %b expected 0", stall_timeout); end
    tick(); @(negedge clk);
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL stall_100: got %b expected 1", stall_timeout); end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL stall_saturate: got %b expected 1", stall_timeout); end
    tick(); id_ready = 1'b1;
    @(negedge clk);
    tick(); id_ready = 1'b0;
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b0 || if_pc !== 32'h4) begin failures++; $display("FAIL stall_clear: got %b/%h expected 0/00000004", stall_timeout, if_pc); end
  endtask

  task automatic test_midop_reset;
    reset_dut(1'b1, 3);
    for (int k = 0; k < 7; k++) begin @(negedge clk); tick(); end
    resetb = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out: got %b/%h/%b expected 1/00000000/0", imem_ready, imem_addr, if_valid); end
    reset_dut(1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== (k >= 2)) begin failures++; $display("FAIL mid_valid c%0d: got %b expected %b", k, if_valid, k >= 2); end
      if (k >= 2) begin
        checks++; if (if_pc !== 32'(4 * (k - 2)) || if_instr !== 32'(k - 2)) begin failures++; $display("FAIL mid_head c%0d: got %h/%h expected %h/%h", k, if_pc, if_instr, 4 * (k - 2), k - 2); end
      end
      tick();
    end
  endtask

  initial begin
    resetb = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_timing();
    test_redirect_flush();
    test_misaligned();
    test_addr_limit();
    test_stall_timeout();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
